// File: rtl/uart_rx_wrapper.sv
// Multi-byte 8N1 UART receiver: bit-level receiver, frame assembler (first byte lands in the MSB)
// and an inter-byte idle timeout that drops partial frames.
module uart_rx_wrapper #(
    parameter int SYS_CLK_PERIOD = 50,
    parameter int BAUD_RATE      = 115200,
    parameter int BYTE_NUM       = 9,
    parameter int TIMEOUT_BITS   = 20
) (
    input  logic                  CLK_I,
    input  logic                  RSTN_I,
    input  logic                  UART_I,
    output logic [BYTE_NUM*8-1:0] DATA_O,
    output logic                  VALID_O,
    output logic                  BUSY_O,
    output logic                  ERR_O,
    output logic                  TIMEOUT_O
);
    localparam int BAUD_DIV     = 1000000000 / (SYS_CLK_PERIOD * BAUD_RATE);
    localparam int HALF_DIV     = BAUD_DIV / 2;
    localparam int TIMEOUT_CLKS = TIMEOUT_BITS * BAUD_DIV;
    localparam int CNT_W        = $clog2(BYTE_NUM + 1);
    localparam int W            = BYTE_NUM * 8;

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK} state_t;

    state_t           state_reg;
    logic             sync_reg;
    logic             rx_s;
    logic [15:0]      baud_cnt_reg;
    logic [31:0]      idle_cnt_reg;
    logic [2:0]       bit_idx_reg;
    logic [7:0]       bits_reg;
    logic [CNT_W-1:0] count_reg;
    logic [W-1:0]     shift_reg;
    logic [W-1:0]     shift_in;
    logic             partial;

    generate
        if (BYTE_NUM == 1) begin : g_single
            assign shift_in = bits_reg;
        end else begin : g_multi
            assign shift_in = {shift_reg[W-9:0], bits_reg};
        end
    endgenerate

    // Idle timer only matters between bytes of an incomplete frame.
    assign partial = (count_reg != '0) && (count_reg < CNT_W'(BYTE_NUM));
    assign BUSY_O  = (state_reg != ST_IDLE) || (count_reg != '0);

    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            sync_reg     <= 1'b1;
            rx_s         <= 1'b1;
            state_reg    <= ST_IDLE;
            baud_cnt_reg <= '0;
            idle_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            bits_reg     <= '0;
            count_reg    <= '0;
            shift_reg    <= '0;
            DATA_O       <= '0;
            VALID_O      <= 1'b0;
            ERR_O        <= 1'b0;
            TIMEOUT_O    <= 1'b0;
        end else begin
            sync_reg  <= UART_I;
            rx_s      <= sync_reg;
            VALID_O   <= 1'b0;
            ERR_O     <= 1'b0;
            TIMEOUT_O <= 1'b0;

            // Frame completion lands one clock after the last good stop sample.
            if (count_reg == CNT_W'(BYTE_NUM)) begin
                DATA_O    <= shift_reg;
                VALID_O   <= 1'b1;
                count_reg <= '0;
            end

            case (state_reg)
                ST_IDLE: begin
                    // A start edge takes priority over a simultaneous timeout expiry.
                    if (!rx_s) begin
                        state_reg    <= ST_START;
                        baud_cnt_reg <= '0;
                        idle_cnt_reg <= '0;
                    end else if (partial) begin
                        if (idle_cnt_reg == 32'(TIMEOUT_CLKS - 1)) begin
                            TIMEOUT_O    <= 1'b1;
                            count_reg    <= '0;
                            idle_cnt_reg <= '0;
                        end else begin
                            idle_cnt_reg <= idle_cnt_reg + 32'd1;
                        end
                    end else begin
                        idle_cnt_reg <= '0;
                    end
                end
                ST_START: begin
                    if (baud_cnt_reg == 16'(HALF_DIV - 1)) begin
                        baud_cnt_reg <= '0;
                        if (rx_s) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            state_reg   <= ST_DATA;
                            bit_idx_reg <= '0;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (baud_cnt_reg == 16'(BAUD_DIV - 1)) begin
                        baud_cnt_reg <= '0;
                        bits_reg     <= {rx_s, bits_reg[7:1]};
                        bit_idx_reg  <= bit_idx_reg + 3'd1;
                        if (bit_idx_reg == 3'd7) begin
                            state_reg <= ST_STOP;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (baud_cnt_reg == 16'(BAUD_DIV - 1)) begin
                        baud_cnt_reg <= '0;
                        if (rx_s) begin
                            shift_reg <= shift_in;
                            count_reg <= count_reg + 1'b1;
                            state_reg <= ST_IDLE;
                        end else begin
                            ERR_O     <= 1'b1;
                            count_reg <= '0;
                            state_reg <= ST_BREAK;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 16'd1;
                    end
                end
                ST_BREAK: begin
                    if (rx_s) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end
endmodule
